// File: rtl/ex_stage_md.sv
// ---------------------------------------------------------------------------
// alu: single-cycle integer ALU used by the execute stage for non-M operations.
//   i_ctrl : op code  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL,
//                     7 SRA, 8 OR, 9 AND, 10 pass B; anything else yields 0
//   i_a    : operand A
//   i_b    : operand B (low log2(BIT_W) bits are the shift amount)
//   o_res  : result
// ---------------------------------------------------------------------------
module alu #(
   parameter int unsigned BIT_W = 32
) (
   input  logic [3:0]       i_ctrl,
   input  logic [BIT_W-1:0] i_a,
   input  logic [BIT_W-1:0] i_b,
   output logic [BIT_W-1:0] o_res
);

   localparam int unsigned SH_W = $clog2(BIT_W);

   logic [SH_W-1:0] w_sh;

   assign w_sh = i_b[SH_W-1:0];

   // Operation select
   always_comb begin
      o_res = '0;
      case (i_ctrl)
         4'd0:    o_res = i_a + i_b;
         4'd1:    o_res = i_a - i_b;
         4'd2:    o_res = i_a << w_sh;
         4'd3:    o_res = BIT_W'($signed(i_a) < $signed(i_b));
         4'd4:    o_res = BIT_W'(i_a < i_b);
         4'd5:    o_res = i_a ^ i_b;
         4'd6:    o_res = i_a >> w_sh;
         4'd7:    o_res = BIT_W'($signed(i_a) >>> w_sh);
         4'd8:    o_res = i_a | i_b;
         4'd9:    o_res = i_a & i_b;
         4'd10:   o_res = i_b;
         default: o_res = '0;
      endcase
   end

endmodule

// ---------------------------------------------------------------------------
// ex_stage_md: execute stage with an iterative RV32M multiply/divide unit,
// full B-type branch resolution and the EX/MEM pipeline register.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   PC_in, rs1/rs2_dat_in, imm : instruction PC, register operands, immediate
//   alusrc_in, aluctrl_in      : ALU operand-B select and op code
//   md_en_in, md_op_in         : M-extension enable and funct3
//   jal_in, jalr_in, branch_in : control-flow type
//   branch_cond_in             : B-type funct3
//   branch_taken_in            : predictor guess
//   stall                      : downstream stall, holds EX/MEM
//   rd_in, memrd/memwr/mem2reg/regwr/compressed_in : passthrough controls
//   forward_A/B_flag, _dat     : forwarded operand override
//   alu_result, mem_wdata, PC_step, rd_out, memrd/memwr/mem2reg/regwr/jump_out
//                              : EX/MEM registered outputs
//   md_busy                    : comb, upstream holds PC and ID/EX while high
//   jump_noblock               : comb, jal | jalr
//   PC_result_noblock          : comb, ALU output
//   prediction_incorrect       : comb, resolved taken ^ predicted
//   feedback_valid             : comb, branch_in & !stall & !md_busy
// ---------------------------------------------------------------------------
module ex_stage_md #(
   parameter int unsigned BIT_W = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [BIT_W-1:0] PC_in,
   input  logic [BIT_W-1:0] rs1_dat_in,
   input  logic [BIT_W-1:0] rs2_dat_in,
   input  logic [BIT_W-1:0] imm,
   input  logic             alusrc_in,
   input  logic [3:0]       aluctrl_in,
   input  logic             md_en_in,
   input  logic [2:0]       md_op_in,
   input  logic             jal_in,
   input  logic             jalr_in,
   input  logic             branch_in,
   input  logic [2:0]       branch_cond_in,
   input  logic             branch_taken_in,
   input  logic             stall,
   input  logic [4:0]       rd_in,
   input  logic             memrd_in,
   input  logic             memwr_in,
   input  logic             mem2reg_in,
   input  logic             regwr_in,
   input  logic             compressed_in,
   input  logic             forward_A_flag,
   input  logic             forward_B_flag,
   input  logic [BIT_W-1:0] forward_A_dat,
   input  logic [BIT_W-1:0] forward_B_dat,
   output logic [BIT_W-1:0] alu_result,
   output logic [BIT_W-1:0] mem_wdata,
   output logic [BIT_W-1:0] PC_step,
   output logic [4:0]       rd_out,
   output logic             memrd_out,
   output logic             memwr_out,
   output logic             mem2reg_out,
   output logic             regwr_out,
   output logic             jump_out,
   output logic             md_busy,
   output logic             jump_noblock,
   output logic [BIT_W-1:0] PC_result_noblock,
   output logic             prediction_incorrect,
   output logic             feedback_valid
);

   localparam int unsigned W  = BIT_W;
   localparam int unsigned W2 = 2 * BIT_W;
   localparam logic [BIT_W-1:0] MOST_NEG = {1'b1, {(BIT_W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [W-1:0]      w_fa;
   logic [W-1:0]      w_fb;
   logic [W-1:0]      w_alu_a;
   logic [W-1:0]      w_alu_b;
   logic [W-1:0]      w_alu_out;
   logic              w_taken;

   // M-unit operand preparation
   logic              w_a_signed;
   logic              w_b_signed;
   logic              w_is_div;
   logic              w_sa;
   logic              w_sb;
   logic [W-1:0]      w_mag_a;
   logic [W-1:0]      w_mag_b;
   logic              w_div0;
   logic              w_ovf;
   logic              w_special;
   logic [W2-1:0]     w_acc_init;

   // M-unit state
   logic [2:0]        r_op;
   logic              r_sa;
   logic              r_sb;
   logic              r_special;
   logic [W-1:0]      r_mag_a;
   logic [W-1:0]      r_mag_b;
   logic [W2-1:0]     r_acc;
   logic [CNT_W-1:0]  r_cnt;

   // Iteration step and result
   logic [W:0]        w_sum;
   logic [W2-1:0]     w_mul_nxt;
   logic [W:0]        w_rem_sh;
   logic [W:0]        w_diff;
   logic              w_ge;
   logic [W2-1:0]     w_div_nxt;
   logic [W2-1:0]     w_prod;
   logic [W-1:0]      w_quo;
   logic [W-1:0]      w_rem;
   logic              w_neg_q;
   logic              w_neg_r;
   logic [W-1:0]      w_md_result;

   logic              w_accept;
   logic              w_step;
   logic              w_md_busy;

   // EX/MEM register
   logic [W-1:0]      r_alu_result;
   logic [W-1:0]      r_mem_wdata;
   logic [W-1:0]      r_pc_step;
   logic [4:0]        r_rd;
   logic              r_memrd;
   logic              r_memwr;
   logic              r_mem2reg;
   logic              r_regwr;
   logic              r_jump;

   // Operand forwarding and ALU operand selection
   assign w_fa    = forward_A_flag ? forward_A_dat : rs1_dat_in;
   assign w_fb    = forward_B_flag ? forward_B_dat : rs2_dat_in;
   assign w_alu_a = (jal_in | branch_in) ? PC_in : w_fa;
   assign w_alu_b = alusrc_in ? imm : w_fb;

   alu #(.BIT_W(BIT_W)) u_alu (
      .i_ctrl (aluctrl_in),
      .i_a    (w_alu_a),
      .i_b    (w_alu_b),
      .o_res  (w_alu_out)
   );

   // Branch condition resolution
   always_comb begin
      w_taken = 1'b0;
      case (branch_cond_in)
         3'd0:    w_taken = (w_fa == w_fb);
         3'd1:    w_taken = (w_fa != w_fb);
         3'd4:    w_taken = ($signed(w_fa) <  $signed(w_fb));
         3'd5:    w_taken = ($signed(w_fa) >= $signed(w_fb));
         3'd6:    w_taken = (w_fa <  w_fb);
         3'd7:    w_taken = (w_fa >= w_fb);
         default: w_taken = 1'b0;
      endcase
   end

   // Operand signedness by funct3: MULH/MULHSU/DIV/REM treat A as signed,
   // MULH/DIV/REM treat B as signed. MUL low half is sign-agnostic.
   assign w_a_signed = (md_op_in == 3'd1) || (md_op_in == 3'd2) ||
                       (md_op_in == 3'd4) || (md_op_in == 3'd6);
   assign w_b_signed = (md_op_in == 3'd1) || (md_op_in == 3'd4) ||
                       (md_op_in == 3'd6);
   assign w_is_div   = md_op_in[2];
   assign w_sa       = w_a_signed & w_fa[W-1];
   assign w_sb       = w_b_signed & w_fb[W-1];
   assign w_mag_a    = w_sa ? -w_fa : w_fa;
   assign w_mag_b    = w_sb ? -w_fb : w_fb;
   assign w_div0     = w_is_div & (w_fb == '0);
   assign w_ovf      = w_is_div & ~md_op_in[0] & (w_fa == MOST_NEG) & (w_fb == '1);
   assign w_special  = w_div0 | w_ovf;

   // Special cases preload the final quotient/remainder so DONE reads them
   // unmodified; normal divides start from the dividend magnitude, multiplies
   // from the multiplier magnitude in the low half.
   always_comb begin
      if (w_div0) begin
         w_acc_init = {w_fa, {W{1'b1}}};
      end else if (w_ovf) begin
         w_acc_init = {{W{1'b0}}, w_fa};
      end else if (w_is_div) begin
         w_acc_init = {{W{1'b0}}, w_mag_a};
      end else begin
         w_acc_init = {{W{1'b0}}, w_mag_b};
      end
   end

   // Shift-add multiply step: conditionally add multiplicand, shift right
   assign w_sum     = {1'b0, r_acc[W2-1:W]} + (r_acc[0] ? {1'b0, r_mag_a} : {(W+1){1'b0}});
   assign w_mul_nxt = {w_sum, r_acc[W-1:1]};

   // Restoring divide step: shift left, subtract divisor if it fits
   assign w_rem_sh  = r_acc[W2-1:W-1];
   assign w_diff    = w_rem_sh - {1'b0, r_mag_b};
   assign w_ge      = ~w_diff[W];
   assign w_div_nxt = {(w_ge ? w_diff[W-1:0] : w_rem_sh[W-1:0]), r_acc[W-2:0], w_ge};

   // Sign correction of the finished magnitude result
   assign w_prod  = (r_sa ^ r_sb) ? -r_acc : r_acc;
   assign w_quo   = r_acc[W-1:0];
   assign w_rem   = r_acc[W2-1:W];
   assign w_neg_q = ~r_special & (r_sa ^ r_sb);
   assign w_neg_r = ~r_special & r_sa;

   always_comb begin
      w_md_result = '0;
      case (r_op)
         3'd0:                w_md_result = w_prod[W-1:0];
         3'd1, 3'd2, 3'd3:    w_md_result = w_prod[W2-1:W];
         3'd4, 3'd5:          w_md_result = w_neg_q ? -w_quo : w_quo;
         default:             w_md_result = w_neg_r ? -w_rem : w_rem;
      endcase
   end

   // M-unit FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // M-unit FSM next state and controls
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      w_md_busy   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (md_en_in && !stall) begin
               w_accept    = 1'b1;
               w_md_busy   = 1'b1;
               w_state_nxt = w_special ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            w_step    = 1'b1;
            w_md_busy = 1'b1;
            if (r_cnt == '0) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            // Upstream advances on the same edge, so IDLE sees the next op
            if (!stall) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // M-unit datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op      <= '0;
         r_sa      <= 1'b0;
         r_sb      <= 1'b0;
         r_special <= 1'b0;
         r_mag_a   <= '0;
         r_mag_b   <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
      end else if (w_accept) begin
         r_op      <= md_op_in;
         r_sa      <= w_sa;
         r_sb      <= w_sb;
         r_special <= w_special;
         r_mag_a   <= w_mag_a;
         r_mag_b   <= w_mag_b;
         r_acc     <= w_acc_init;
         r_cnt     <= CNT_W'(BIT_W - 1);
      end else if (w_step) begin
         r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   // EX/MEM register: hold on stall, bubble while the M-unit is busy.
   // Data fields keep their old value during a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_result <= '0;
         r_mem_wdata  <= '0;
         r_pc_step    <= '0;
         r_rd         <= '0;
         r_memrd      <= 1'b0;
         r_memwr      <= 1'b0;
         r_mem2reg    <= 1'b0;
         r_regwr      <= 1'b0;
         r_jump       <= 1'b0;
      end else if (!stall) begin
         if (w_md_busy) begin
            r_memrd   <= 1'b0;
            r_memwr   <= 1'b0;
            r_mem2reg <= 1'b0;
            r_regwr   <= 1'b0;
            r_jump    <= 1'b0;
         end else begin
            r_alu_result <= md_en_in ? w_md_result : w_alu_out;
            r_mem_wdata  <= w_fb;
            r_pc_step    <= PC_in + (compressed_in ? W'(2) : W'(4));
            r_rd         <= rd_in;
            r_memrd      <= memrd_in;
            r_memwr      <= memwr_in;
            r_mem2reg    <= mem2reg_in;
            r_regwr      <= regwr_in;
            r_jump       <= jal_in | jalr_in;
         end
      end
   end

   assign alu_result           = r_alu_result;
   assign mem_wdata            = r_mem_wdata;
   assign PC_step              = r_pc_step;
   assign rd_out               = r_rd;
   assign memrd_out            = r_memrd;
   assign memwr_out            = r_memwr;
   assign mem2reg_out          = r_mem2reg;
   assign regwr_out            = r_regwr;
   assign jump_out             = r_jump;
   assign md_busy              = w_md_busy;
   assign jump_noblock         = jal_in | jalr_in;
   assign PC_result_noblock    = w_alu_out;
   assign prediction_incorrect = w_taken ^ branch_taken_in;
   assign feedback_valid       = branch_in & ~stall & ~w_md_busy;

endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
Parametrised next-generation execute stage for the RISC-V pipeline. It adds an iterative RV32M multiply/divide unit that stalls upstream while busy. It also resolves the full branch-condition set (BEQ/BNE/BLT/BGE/BLTU/BGEU) instead of equality only. It sits between the ID/EX and EX/MEM boundaries, owns the EX/MEM register, and reuses the existing alu module for non-M operations.

Parameters:
BIT_W, 32, datapath width (must be even, >= 8)
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > BIT_W

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
PC_in  input  BIT_W  instruction PC
rs1_dat_in, rs2_dat_in  input  BIT_W  register operands
imm  input  BIT_W  immediate
alusrc_in  input  1  ALU operand B = imm
aluctrl_in  input  4  alu op code
md_en_in  input  1  instruction is an M-extension op
md_op_in  input  3  M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
jal_in, jalr_in, branch_in  input  1  control
branch_cond_in  input  3  B-type funct3
branch_taken_in  input  1  predictor's guess
stall  input  1  downstream stall; hold EX/MEM
rd_in  input  5  destination register
memrd_in, memwr_in, mem2reg_in, regwr_in, compressed_in  input  1  passthrough controls
forward_A_flag, forward_B_flag  input  1  select forwarded data
forward_A_dat, forward_B_dat  input  BIT_W  forwarded data
alu_result, mem_wdata, PC_step  output  BIT_W  EX/MEM registered outputs
rd_out  output  5  registered
memrd_out, memwr_out, mem2reg_out, regwr_out, jump_out  output  1  registered
md_busy  output  1  combinational; upstream must hold PC and ID/EX while high
jump_noblock  output  1  jal_in | jalr_in, combinational
PC_result_noblock  output  BIT_W  alu output, combinational
prediction_incorrect  output  1  combinational
feedback_valid  output  1  branch_in & !stall & !md_busy

Behaviour:
- Reset: all EX/MEM outputs are 0, FSM = IDLE, counter = 0. Reset is asynchronous, so a reset mid-divide aborts the operation and no result is written.
- Operands:
  - fA = forward_A_flag ? forward_A_dat : rs1_dat_in; fB likewise.
  - alu A = (jal_in | branch_in) ? PC_in : fA.
  - alu B = alusrc_in ? imm : fB.
- Branch taken by funct3:
  - 0: fA == fB; 1: fA != fB.
  - 4: signed fA < fB; 5: signed fA >= fB.
  - 6: unsigned fA < fB; 7: unsigned fA >= fB.
  - 2/3: taken = 0.
  - prediction_incorrect = taken ^ branch_taken_in.
- FSM IDLE:
  - If md_en_in & !stall: latch operand magnitudes, signs and op, and set counter = BIT_W-1.
  - Go to RUN, or straight to DONE for the special divide cases below.
  - md_busy = 1 in the accepting cycle.
- FSM RUN:
  - One shift-add (multiply) or one restoring-subtract (divide) step per cycle, over a 2*BIT_W working register.
  - md_busy = 1. Go to DONE when counter == 0; otherwise decrement.
- FSM DONE:
  - md_busy = 0; the sign-corrected result drives the EX/MEM input.
  - !stall: load EX/MEM and go to IDLE; the upstream advances in the same edge, so there is no re-accept.
  - stall: remain in DONE with the result held.
- Latency: md_busy is high for BIT_W+1 cycles (33 by default), and alu_result is updated at the edge ending DONE.
- EX/MEM loading:
  - While md_busy & !stall, EX/MEM loads a bubble: regwr/memrd/memwr/mem2reg/jump = 0, data fields don't-care.
  - When stall is high, every EX/MEM field holds.
  - Otherwise load:
    - alu_result = md_en_in ? md_result : alu out;
    - mem_wdata = fB;
    - PC_step = PC_in + (compressed_in ? 2 : 4), modulo 2^BIT_W;
    - jump_out = jal_in | jalr_in;
    - rd and the passthrough controls from their inputs.
- Result selection:
  - MUL returns the low BIT_W bits.
  - MULH/MULHSU/MULHU return the high BIT_W bits; the operand treated as signed per op has its product negated when the signs differ.
  - DIV/REM: quotient sign = sA ^ sB, remainder sign = sA.
- Special cases, 1-cycle path (accept goes directly to DONE):
  - divisor 0: quotient = all ones, remainder = dividend.
  - signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
- Simultaneous md_en_in and stall in IDLE: the op is not accepted, md_busy = 0 and everything holds.

Test Plan:
- MUL 7 * -3, rd=5 -> md_busy high 33 cycles, then alu_result = 0xFFFFFFEB, rd_out = 5, regwr_out = 1; bubbles (regwr_out = 0) while busy.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHSU -1 * 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF with busy for 1 cycle; DIV 0x80000000 / -1 -> 0x80000000; REM of the same -> 0.
- Assert stall for 3 cycles in DONE -> outputs hold and the FSM stays in DONE; on release, result loads once and the next instruction is accepted the following cycle.
- BLT fA = -1, fB = 1, branch_taken_in = 0 -> prediction_incorrect = 1, feedback_valid = 1; BLTU with the same operands -> prediction_incorrect = 0.
- rst_n low for 1 cycle mid-RUN (cycle 10) -> all outputs 0 immediately, FSM IDLE, md_busy = 0.
